// File: rtl/motion_pkg.sv
// motion_pkg: shared types and helpers for the motion stream core.
// Bundles are sized by CHAN_W here; keep it equal to the top's CHAN_W.
package motion_pkg;

    localparam int CHAN_W = 8;

    typedef enum logic [1:0] {
        MODE_HL   = 2'd0,
        MODE_MASK = 2'd1,
        MODE_PASS = 2'd2
    } mode_e;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [CHAN_W-1:0] x;
        rgb_t              c;
    } pix_t;

    typedef struct packed {
        logic              valid;
        pix_t              word;
        logic [CHAN_W-1:0] gray_fr;
        logic [CHAN_W-1:0] gray_bg;
        logic [CHAN_W-1:0] thr;
        mode_e             mode;
    } s1_t;

    typedef struct packed {
        logic              valid;
        pix_t              word;
        logic [CHAN_W-1:0] diff;
        logic [CHAN_W-1:0] thr;
        mode_e             mode;
    } s2_t;

    function automatic logic [CHAN_W-1:0] gray_of(input rgb_t c);
        logic [CHAN_W+1:0] sum;
        sum = {2'b00, c.r} + {1'b0, c.g, 1'b0} + {2'b00, c.b};
        return CHAN_W'(sum >> 2);
    endfunction

    // The reserved encoding falls back to pass-through.
    function automatic mode_e to_mode(input logic [1:0] m);
        mode_e md;
        case (m)
            2'd0:    md = MODE_HL;
            2'd1:    md = MODE_MASK;
            default: md = MODE_PASS;
        endcase
        return md;
    endfunction

endpackage

// File: rtl/motion_stream_core_frame_ctr.sv
// motion_frame_ctr: pixel-in-frame counter wrapping at FRAME_PIXELS.
// Flags the first and last pixel position of the current frame.
module motion_frame_ctr #(
    parameter int FRAME_PIXELS = 76800
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    output logic first_o,
    output logic last_o
);

    localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motion_stream_core.sv
// motion_stream_core: 3-stage stall-aware gray-difference motion pipeline.
// Optional motion_count output is enabled by defining MOTION_STATS_EN.
module motion_stream_core #(
    parameter int                  CHAN_W       = motion_pkg::CHAN_W,
    parameter int                  FRAME_PIXELS = 76800,
    parameter logic [3*CHAN_W-1:0] HL_COLOR     = 24'hFF0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*CHAN_W-1:0] bg_dout,
    input  logic                bg_empty,
    output logic                bg_rd_en,
    input  logic [4*CHAN_W-1:0] fr_dout,
    input  logic                fr_empty,
    output logic                fr_rd_en,
    output logic [4*CHAN_W-1:0] out_din,
    input  logic                out_full,
    output logic                out_wr_en,
    input  logic [CHAN_W-1:0]   threshold,
    input  logic [1:0]          mode,
    output logic                frame_done,
    output logic                busy
`ifdef MOTION_STATS_EN
    ,
    output logic [$clog2(FRAME_PIXELS+1)-1:0] motion_count
`endif
);

    import motion_pkg::*;

    s1_t                s1_q;
    s1_t                s1_d;
    s2_t                s2_q;
    s2_t                s2_d;
    logic               s3_valid_q;
    logic [4*CHAN_W-1:0] s3_word_q;
    logic [4*CHAN_W-1:0] s3_word_d;

    logic [CHAN_W-1:0]  frame_thr_q;
    logic [CHAN_W-1:0]  frame_thr_d;
    mode_e              frame_mode_q;
    mode_e              frame_mode_d;

    logic               advance;
    logic               pop;
    logic               motion;
    logic               in_first;
    logic               in_last;
    logic               out_first;
    logic               out_last;
    pix_t               bg_pix;
    pix_t               fr_pix;

    assign advance = !(s3_valid_q && out_full);
    assign pop     = advance && !bg_empty && !fr_empty;
    assign bg_pix  = bg_dout;
    assign fr_pix  = fr_dout;

    motion_frame_ctr #(
        .FRAME_PIXELS(FRAME_PIXELS)
    ) u_in_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (pop),
        .first_o(in_first),
        .last_o (in_last)
    );

    motion_frame_ctr #(
        .FRAME_PIXELS(FRAME_PIXELS)
    ) u_out_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (out_wr_en),
        .first_o(out_first),
        .last_o (out_last)
    );

    // A frame's first pop uses the live inputs and latches them.
    always_comb begin
        frame_thr_d  = frame_thr_q;
        frame_mode_d = frame_mode_q;
        if (pop && in_first) begin
            frame_thr_d  = threshold;
            frame_mode_d = to_mode(mode);
        end
    end

    always_comb begin
        s1_d         = '0;
        s1_d.valid   = pop;
        s1_d.word    = fr_pix;
        s1_d.gray_fr = gray_of(fr_pix.c);
        s1_d.gray_bg = gray_of(bg_pix.c);
        s1_d.thr     = in_first ? threshold : frame_thr_q;
        s1_d.mode    = in_first ? to_mode(mode) : frame_mode_q;
    end

    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.word  = s1_q.word;
        s2_d.thr   = s1_q.thr;
        s2_d.mode  = s1_q.mode;
        if (s1_q.gray_fr >= s1_q.gray_bg) begin
            s2_d.diff = s1_q.gray_fr - s1_q.gray_bg;
        end else begin
            s2_d.diff = s1_q.gray_bg - s1_q.gray_fr;
        end
    end

    always_comb begin
        motion    = (s2_q.diff > s2_q.thr);
        s3_word_d = s2_q.word;
        case (s2_q.mode)
            MODE_HL: begin
                if (motion) begin
                    s3_word_d = {s2_q.word.x, HL_COLOR};
                end
            end
            MODE_MASK: s3_word_d = motion ? '1 : '0;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_thr_q  <= '0;
            frame_mode_q <= MODE_HL;
        end else begin
            frame_thr_q  <= frame_thr_d;
            frame_mode_q <= frame_mode_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_valid_q <= 1'b0;
            s3_word_q  <= '0;
        end else if (advance) begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_valid_q <= s2_q.valid;
            s3_word_q  <= s3_word_d;
        end
    end

    assign bg_rd_en   = pop;
    assign fr_rd_en   = pop;
    assign out_wr_en  = s3_valid_q && !out_full;
    assign out_din    = s3_word_q;
    assign frame_done = out_wr_en && out_last;
    assign busy       = s1_q.valid || s2_q.valid || s3_valid_q
                     || !in_first || !out_first;

`ifdef MOTION_STATS_EN
    localparam int MC_W = $clog2(FRAME_PIXELS + 1);

    logic            s3_motion_q;
    logic [MC_W-1:0] acc_q;
    logic [MC_W-1:0] acc_d;
    logic [MC_W-1:0] mc_q;
    logic [MC_W-1:0] mc_d;

    // Total includes the frame's last pixel, written in the same cycle.
    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        if (out_wr_en) begin
            if (out_last) begin
                mc_d  = acc_q + MC_W'(s3_motion_q);
                acc_d = '0;
            end else begin
                acc_d = acc_q + MC_W'(s3_motion_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_motion_q <= 1'b0;
            acc_q       <= '0;
            mc_q        <= '0;
        end else begin
            if (advance) begin
                s3_motion_q <= motion;
            end
            acc_q <= acc_d;
            mc_q  <= mc_d;
        end
    end

    assign motion_count = mc_q;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

endmodule
